// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the 16-bit MIPS-style core
//
// Purpose : instruction width, the NOP encoding and the instruction word type,
//           shared by the fetch-side blocks.
// Contents: INSTR_W, NOP_INSTR, instr_t
package mips_pkg;

   localparam int INSTR_W = 16;

   typedef logic [INSTR_W-1:0] instr_t;

   localparam instr_t NOP_INSTR = 16'h0000;

endpackage

// File: rtl/mips_instruction_mem.sv
// rtl/mips_instruction_mem.sv - word-indexed instruction memory with combinational fetch
//
// Purpose : 2**ADDR_W x 16-bit program store. The read path is purely
//           combinational so fetch sees the word in the same cycle PC moves;
//           the write port loads the program on rising clk. An asynchronous
//           active-low reset clears every word to NOP.
// Macro   : MIPS_IMEM_BOUNDS_CHECK_EN - when defined, adds addr_err and forces
//           NOP for any PC beyond the array; otherwise PC wraps modulo depth.
// Ports   :
//   clk         in  write-port clock, rising edge
//   rst_n       in  asynchronous active-low reset, clears the array
//   we          in  write enable for program load
//   waddr       in  [ADDR_W-1:0] word index to write
//   wdata       in  [DATA_W-1:0] instruction word to write
//   PC          in  [31:0] program counter, a word index (no byte shift)
//   instruction out [DATA_W-1:0] word selected by PC
//   addr_err    out PC out of range (bounds-check build only)
module mips_instruction_mem
   import mips_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [31:0]       PC,
`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
   output logic              addr_err,
`endif
   output logic [DATA_W-1:0] instruction
);

   localparam int DEPTH = 2 ** ADDR_W;

   instr_t            mem [DEPTH];
   logic [ADDR_W-1:0] idx;

   assign idx = PC[ADDR_W-1:0];

   // Reset wins over any write in flight, so a write held during reset (or
   // on the edge that coincides with release) never lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= NOP_INSTR;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
   assign addr_err    = |PC[31:ADDR_W];
   assign instruction = addr_err ? NOP_INSTR : mem[idx];
`else
   // Upper PC bits are deliberately ignored: fetch wraps modulo depth.
   logic unused_pc_hi;
   assign unused_pc_hi = |PC[31:ADDR_W];
   assign instruction  = mem[idx];
`endif

endmodule

// File: tb/tb_mips_instruction_mem.sv
// tb/tb_mips_instruction_mem.sv - self-checking bench for mips_instruction_mem
module tb_mips_instruction_mem;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic              clk;
   logic              rst_n;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [15:0]       wdata;
   logic [31:0]       PC;
   logic [15:0]       instruction;
`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
   logic              addr_err;
`endif

   mips_instruction_mem #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .PC          (PC),
`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
      .addr_err    (addr_err),
`endif
      .instruction (instruction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] model [DEPTH];

   task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (PC=%0d)", tag, got, exp, PC);
      end
   endtask

   task automatic check1(input string tag, input logic got, input logic exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b (PC=%0d)", tag, got, exp, PC);
      end
   endtask

   // Expected fetch result from the specification: word index is PC mod depth,
   // and with bounds checking any nonzero upper bit yields NOP.
   function automatic logic [15:0] expect_fetch(input logic [31:0] pc);
      int unsigned word;
      word = pc % DEPTH;
`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
      if (pc >= DEPTH) return 16'h0000;
`endif
      return model[word];
   endfunction

   task automatic fetch_check(input string tag, input logic [31:0] pc);
      PC = pc;
      #1;
      check16(tag, instruction, expect_fetch(pc));
`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
      check1({tag, "_err"}, addr_err, pc >= DEPTH);
`endif
   endtask

   task automatic write_word(input int unsigned a, input logic [15:0] d, input logic en);
      @(negedge clk);
      we    = en;
      waddr = a[ADDR_W-1:0];
      wdata = d;
      @(posedge clk);
      #1;
      if (en) model[a % DEPTH] = d;
      we = 1'b0;
   endtask

   initial begin
      logic [31:0] rpc;
      logic [15:0] old_word;

      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      PC    = '0;
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;

      // Reset: array reads zero while rst_n is held low.
      PC = 32'd0; #10; check16("rst_pc0", instruction, 16'h0000);
      PC = 32'd1; #10; check16("rst_pc1", instruction, 16'h0000);
      PC = 32'd2; #10; check16("rst_pc2", instruction, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Load and fetch.
      write_word(0, 16'hA001, 1'b1);
      write_word(1, 16'hB002, 1'b1);
      write_word(2, 16'hC003, 1'b1);
      PC = 32'd0; #1; check16("fetch0", instruction, 16'hA001); #9;
      PC = 32'd1; #1; check16("fetch1", instruction, 16'hB002); #9;
      PC = 32'd2; #1; check16("fetch2", instruction, 16'hC003); #9;

      // Write timing: old word before the edge, new word right after.
      PC = 32'd5;
      @(negedge clk);
      old_word = model[5];
      we = 1'b1; waddr = 6'd5; wdata = 16'h1234;
      #1;
      check16("pre_edge_old", instruction, old_word);
      @(posedge clk);
      #1;
      model[5] = 16'h1234;
      we = 1'b0;
      check16("post_edge_new", instruction, 16'h1234);
      write_word(5, 16'hFFFF, 1'b0);
      check16("we0_hold", instruction, 16'h1234);

      // Randomized writes and fetches against the reference array.
      for (int n = 0; n < 150; n++) begin
         write_word($urandom_range(DEPTH - 1), 16'($urandom), ($urandom_range(3) != 0));
         rpc = ($urandom_range(4) == 0) ? 32'($urandom) : 32'($urandom_range(DEPTH - 1));
         fetch_check("rand_fetch", rpc);
      end

      // Async reset mid-run, between edges, with a write held during reset.
      PC = 32'd1;
      write_word(1, 16'h7777, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check16("async_rst_now", instruction, 16'h0000);
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
      we = 1'b1; waddr = 6'd1; wdata = 16'hDEAD;
      @(posedge clk);
      #1;
      check16("rst_write_drop", instruction, 16'h0000);
      we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i += 7) fetch_check("post_rst_zero", 32'(i));

      // Out-of-range PC.
      write_word(1, 16'h5555, 1'b1);
      PC = 32'd65;
      #1;
`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
      check16("oob_nop", instruction, 16'h0000);
      check1("oob_err", addr_err, 1'b1);
`else
      check16("oob_wrap", instruction, 16'h5555);
`endif
      fetch_check("oob_hi", 32'h8000_0001);

      // Full-depth sweep.
      for (int i = 0; i < DEPTH; i++) write_word(i, 16'(i), 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         PC = 32'(i);
         #1;
         check16("sweep", instruction, 16'(i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
